// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multi-cycle multiply/divide unit.
//   muldiv_op_t    : operation select (MULT, MULTU, DIV, DIVU)
//   muldiv_state_t : sequencer states
//   op_is_div / op_is_signed : operation decode helpers
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
//   start, op, port_a, port_b, flush : request side (into the unit)
//   busy, done, div_zero, hi, lo     : status and HI/LO results (out of the unit)
// Modports: muldiv (the unit itself), tb (the mirror, for the requester).
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);

    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] port_a;
    logic [WIDTH-1:0] port_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport muldiv (
        input  start, op, port_a, port_b, flush,
        output busy, done, div_zero, hi, lo
    );

    modport tb (
        output start, op, port_a, port_b, flush,
        input  busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide unit writing the HI/LO registers.
// Shift-add multiplier and restoring divider, one bit per cycle, operating
// on magnitudes; signs are re-applied in a single FIXUP cycle.
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : muldiv_unit_if.muldiv (start/op/port_a/port_b/flush in;
//          busy/done/div_zero/hi/lo out, all registered)
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    muldiv_unit_if.muldiv bus
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned W2 = 2 * WIDTH;

    muldiv_state_t    state, state_next;
    muldiv_op_t       op_q, op_next;
    logic [CW-1:0]    cnt, cnt_next;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [W2-1:0]    acc, acc_next;
    // Multiplicand (multiply) or divisor (divide), as a magnitude.
    logic [WIDTH-1:0] opnd, opnd_next;
    logic             neg_res, neg_res_next;
    logic             neg_rem, neg_rem_next;
    logic             dz, dz_next;
    logic [WIDTH-1:0] hi_q, hi_next;
    logic [WIDTH-1:0] lo_q, lo_next;
    logic             div_zero_q, div_zero_next;
    logic             busy_q, done_q;

    // Request decode and operand magnitudes
    logic             in_signed, in_div, in_dz;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign in_signed = op_is_signed(bus.op);
    assign in_div    = op_is_div(bus.op);
    assign in_dz     = in_div && (bus.port_b == '0);
    assign abs_a     = (in_signed && bus.port_a[WIDTH-1]) ? -bus.port_a : bus.port_a;
    assign abs_b     = (in_signed && bus.port_b[WIDTH-1]) ? -bus.port_b : bus.port_b;

    // One shift-add multiply step: conditionally add, then shift right
    logic [WIDTH:0]  mul_sum;
    logic [W2-1:0]   mul_step;

    assign mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // One restoring divide step: shift remainder in, trial subtract
    logic [WIDTH:0]  rem_sh, trial;
    logic            q_bit;
    logic [W2-1:0]   div_step;

    assign rem_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, opnd};
    assign q_bit    = ~trial[WIDTH];
    assign div_step = {(q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       acc[WIDTH-2:0], q_bit};

    // Sign fixup of finished magnitudes
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo, rem;

    assign prod = neg_res ? -acc : acc;
    assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_rem ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

    // Next-state and datapath update
    always_comb begin
        state_next    = state;
        op_next       = op_q;
        cnt_next      = cnt;
        acc_next      = acc;
        opnd_next     = opnd;
        neg_res_next  = neg_res;
        neg_rem_next  = neg_rem;
        dz_next       = dz;
        hi_next       = hi_q;
        lo_next       = lo_q;
        div_zero_next = div_zero_q;

        if (bus.flush) begin
            // Abort wins over everything, including a same-cycle start
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    state_next = IDLE;
                    if (bus.start) begin
                        op_next      = bus.op;
                        cnt_next     = '0;
                        neg_res_next = in_signed && (bus.port_a[WIDTH-1] ^ bus.port_b[WIDTH-1]);
                        neg_rem_next = in_signed && bus.port_a[WIDTH-1];
                        dz_next      = in_dz;
                        if (in_div) begin
                            // Divide by zero keeps the raw dividend for HI
                            acc_next  = {{WIDTH{1'b0}}, (in_dz ? bus.port_a : abs_a)};
                            opnd_next = abs_b;
                        end else begin
                            acc_next  = {{WIDTH{1'b0}}, abs_b};
                            opnd_next = abs_a;
                        end
                        state_next = in_dz ? FIXUP : CALC;
                    end
                end
                CALC: begin
                    acc_next = op_is_div(op_q) ? div_step : mul_step;
                    cnt_next = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state_next = FIXUP;
                    end
                end
                FIXUP: begin
                    if (dz) begin
                        hi_next       = acc[WIDTH-1:0];
                        lo_next       = '1;
                        div_zero_next = 1'b1;
                    end else if (op_is_div(op_q)) begin
                        hi_next       = rem;
                        lo_next       = quo;
                        div_zero_next = 1'b0;
                    end else begin
                        hi_next       = prod[W2-1:WIDTH];
                        lo_next       = prod[WIDTH-1:0];
                        div_zero_next = 1'b0;
                    end
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered status outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_q       <= MULT;
            cnt        <= '0;
            acc        <= '0;
            opnd       <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            dz         <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            op_q       <= op_next;
            cnt        <= cnt_next;
            acc        <= acc_next;
            opnd       <= opnd_next;
            neg_res    <= neg_res_next;
            neg_rem    <= neg_rem_next;
            dz         <= dz_next;
            hi_q       <= hi_next;
            lo_q       <= lo_next;
            div_zero_q <= div_zero_next;
            busy_q     <= (state_next == CALC) || (state_next == FIXUP);
            done_q     <= (state_next == DONE);
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes the reference result
// for every accepted request; a monitor pops and compares on each done pulse.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } res_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;

    always #5 CLK = ~CLK;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    res_t exp_q[$];
    res_t last_res;
    int   checks = 0;
    int   errors = 0;

    // Reference: plain wide arithmetic on the architectural definition
    function automatic res_t model(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t         r;
        longint       sa, sb, p;
        logic [2*W-1:0] up;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        r.dz = 1'b0;
        r.hi = '0;
        r.lo = '0;
        case (o)
            MULT: begin
                p = sa * sb;
                r.hi = p[2*W-1:W];
                r.lo = p[W-1:0];
            end
            MULTU: begin
                up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r.hi = up[2*W-1:W];
                r.lo = up[W-1:0];
            end
            DIV: begin
                if (b == '0) begin
                    r.lo = '1; r.hi = a; r.dz = 1'b1;
                end else begin
                    p = sa / sb;
                    r.lo = p[W-1:0];
                    p = sa % sb;
                    r.hi = p[W-1:0];
                end
            end
            default: begin
                if (b == '0) begin
                    r.lo = '1; r.hi = a; r.dz = 1'b1;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge CLK) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with no request outstanding (t=%0t)", $time);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("result_hi", bus.hi, e.hi);
                check("result_lo", bus.lo, e.lo);
                check("result_div_zero", W'(bus.div_zero), W'(e.dz));
            end
        end
    end

    // Issue one request (called at a negedge), wait for done; optionally
    // pulse a stray start with junk operands at a given iteration.
    task automatic run_op(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, output int lat);
        res_t e;
        bit   busy_ok;
        bus.op     = o;
        bus.port_a = a;
        bus.port_b = b;
        bus.start  = 1'b1;
        e = model(o, a, b);
        exp_q.push_back(e);
        last_res = e;
        @(negedge CLK);
        bus.start  = 1'b0;
        bus.port_a = $urandom;
        bus.port_b = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat == inject_at) begin
                bus.start = 1'b1;
                bus.op    = muldiv_op_t'(2'($urandom));
            end
            @(negedge CLK);
            bus.start = 1'b0;
            lat++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", lat);
        end
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        check("busy_window", W'(busy_ok), W'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        muldiv_op_t ro;

        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.op     = MULTU;
        bus.port_a = '0;
        bus.port_b = '0;

        #2 nRST = 1'b0;
        #10;
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        check("rst_busy", W'(bus.busy), '0);
        check("rst_done", W'(bus.done), '0);
        check("rst_div_zero", W'(bus.div_zero), '0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // Full-width unsigned multiply, latency and single-cycle done
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat);
        check("multu_latency", W'(lat), W'(W + 1));
        @(negedge CLK);
        check("done_one_cycle", W'(bus.done), '0);

        // Signed multiply then back-to-back signed divide from DONE
        run_op(MULT, 32'hFFFF_FFFD, 32'd5, -1, lat);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, -1, lat);
        check("b2b_latency", W'(lat), W'(W + 1));
        @(negedge CLK);

        run_op(DIVU, 32'd7, 32'd2, -1, lat);
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat);
        @(negedge CLK);

        // Divide by zero skips the iterations
        run_op(DIVU, 32'h0000_1234, 32'd0, -1, lat);
        check("divzero_latency", W'(lat), W'(1));
        run_op(MULTU, 32'd2, 32'd3, -1, lat);
        @(negedge CLK);

        // Start while busy is ignored
        run_op(MULTU, 32'h0001_2345, 32'h0000_0ABC, 5, lat);
        check("ignored_start_latency", W'(lat), W'(W + 1));
        @(negedge CLK);

        // Flush mid-calculation: no done, HI/LO unchanged
        bus.op = MULTU; bus.port_a = 32'h1111_1111; bus.port_b = 32'h0000_0007;
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (10) @(negedge CLK);
        bus.flush = 1'b1;
        @(negedge CLK);
        bus.flush = 1'b0;
        check("flush_busy", W'(bus.busy), '0);
        check("flush_done", W'(bus.done), '0);
        check("flush_hi_held", bus.hi, last_res.hi);
        check("flush_lo_held", bus.lo, last_res.lo);
        repeat (40) @(negedge CLK);
        check("flush_idle_busy", W'(bus.busy), '0);

        // Flush and start together: start dropped
        bus.op = DIVU; bus.port_a = 32'd99; bus.port_b = 32'd0;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", W'(bus.busy), '0);
        repeat (40) @(negedge CLK);
        check("flush_start_div_zero", W'(bus.div_zero), W'(last_res.dz));

        // Asynchronous reset mid-calculation
        bus.op = DIVU; bus.port_a = 32'hDEAD_BEEF; bus.port_b = 32'd3;
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (8) @(negedge CLK);
        #3 nRST = 1'b0;
        #1;
        check("async_rst_busy", W'(bus.busy), '0);
        check("async_rst_done", W'(bus.done), '0);
        check("async_rst_hi", bus.hi, '0);
        check("async_rst_lo", bus.lo, '0);
        check("async_rst_div_zero", W'(bus.div_zero), '0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        run_op(DIVU, 32'd100, 32'd7, -1, lat);
        check("post_rst_latency", W'(lat), W'(W + 1));
        @(negedge CLK);

        // Randomized mix with corner operands, sometimes back-to-back
        for (int i = 0; i < 40; i++) begin
            ro = muldiv_op_t'(2'($urandom));
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'd1;
                2:       rb = '1;
                3:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = '0;
                2:       ra = $urandom_range(0, 255);
                default: ra = $urandom;
            endcase
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1, lat);
            if ($urandom_range(0, 1) == 1) @(negedge CLK);
        end

        @(negedge CLK);
        check("queue_drained", W'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
